// File: rtl/prog_clock_divider_if.sv
// Configuration and output bundle for prog_clock_divider.
// The master side writes ratios and pulses sync. The slave side is the divider itself.
interface prog_clock_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              sync;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] div_tick;
  logic [NUM_CH-1:0] cfg_pend;

  modport master (
    output cfg_wr, cfg_ch, cfg_div, sync,
    input  div_clk, div_tick, cfg_pend
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_div, sync,
    output div_clk, div_tick, cfg_pend
  );
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable integer clock divider. Shadowed ratios take effect at
// period boundaries, on sync, or immediately when a stopped channel is given a ratio.
module prog_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input logic                 clk,
  input logic                 rst,
  prog_clock_divider_if.slave bus
);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Number of high cycles in a period of n cycles: ceil(n/2).
  function automatic logic [CNT_W-1:0] high_len(input logic [CNT_W-1:0] n);
    return n - (n >> 1);
  endfunction

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  act_q [NUM_CH];
  logic [CNT_W-1:0]  act_d [NUM_CH];
  logic [CNT_W-1:0]  shd_q [NUM_CH];
  logic [CNT_W-1:0]  shd_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] div_clk_q, div_clk_d;
  logic [NUM_CH-1:0] div_tick_q, div_tick_d;
  logic              wr_ok;

  always_comb begin
    wr_ok = bus.cfg_wr && (32'(bus.cfg_ch) < 32'(NUM_CH));
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]      = cnt_q[i];
      act_d[i]      = act_q[i];
      shd_d[i]      = shd_q[i];
      pend_d[i]     = pend_q[i];
      div_clk_d[i]  = 1'b0;
      div_tick_d[i] = 1'b0;

      if (act_q[i] == '0) begin
        // Stopped: hold at zero and restart as soon as any pending ratio lands.
        cnt_d[i] = '0;
        if (pend_q[i]) begin
          act_d[i]  = shd_q[i];
          pend_d[i] = 1'b0;
        end
      end else if (bus.sync || (cnt_q[i] == act_q[i] - ONE)) begin
        cnt_d[i] = '0;
        if (pend_q[i]) begin
          act_d[i]  = shd_q[i];
          pend_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end

      // The write comes after wrap/sync, so a write on a boundary waits one more period.
      if (wr_ok && (32'(bus.cfg_ch) == 32'(i))) begin
        shd_d[i]  = bus.cfg_div;
        pend_d[i] = 1'b1;
      end

      div_clk_d[i]  = (act_d[i] != '0) && (cnt_d[i] < high_len(act_d[i]));
      div_tick_d[i] = (act_d[i] != '0) && (cnt_d[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= DEF_DIV - ONE;
        act_q[i] <= DEF_DIV;
        shd_q[i] <= DEF_DIV;
      end
      pend_q     <= '0;
      div_clk_q  <= '0;
      div_tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        act_q[i] <= act_d[i];
        shd_q[i] <= shd_d[i];
      end
      pend_q     <= pend_d;
      div_clk_q  <= div_clk_d;
      div_tick_q <= div_tick_d;
    end
  end

  assign bus.div_clk  = div_clk_q;
  assign bus.div_tick = div_tick_q;
  assign bus.cfg_pend = pend_q;
endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Multi-channel programmable integer clock divider. Each of NUM_CH channels divides `clk` by a runtime-programmable ratio N, producing a near-50%-duty divided waveform and a one-cycle period-start tick. It replaces fixed power-of-two divider taps wherever a subsystem needs arbitrary or changeable rates. Ratio changes are glitch-free because they take effect only at period boundaries. All outputs are synchronous to `clk`; divided outputs are intended as clock enables or low-rate strobes, not as clock-tree roots.

## Interface
- `NUM_CH`, default 4: number of independent divider channels (1..16).
- `CNT_W`, default 8: counter/ratio width; maximum ratio is 2^CNT_W-1.
- `DEFAULT_DIV`, default 2: ratio loaded into every channel at reset (1..2^CNT_W-1).
- `CH_W`, derived: max(1, clog2(NUM_CH)).

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_wr`  in  1  write strobe for ratio shadow register.
- `cfg_ch`  in  CH_W  target channel for write; values ≥ NUM_CH are ignored.
- `cfg_div`  in  CNT_W  new ratio; 0 means stop channel.
- `sync`  in  1  one-cycle pulse; restarts all running channels phase-aligned.
- `div_clk`  out  NUM_CH  divided waveform per channel.
- `div_tick`  out  NUM_CH  one-cycle pulse on first cycle of each period.
- `cfg_pend`  out  NUM_CH  shadow ratio written but not yet applied.

## Operation
- Per channel state: `cnt` (CNT_W), `act` (applied ratio), `shd` (shadow ratio), `pend` flag.
- Running channel (act ≥ 1): `cnt` counts 0..act-1 and then wraps to 0. The wrap edge is the edge on which `cnt` becomes 0.
- At a wrap edge, if `pend` is set: `act` ← `shd` and `pend` clears. The new period uses the new ratio from its first cycle.
- `div_clk` = 1 while cnt < act − floor(act/2). It is high for ceil(N/2) cycles and low for floor(N/2) cycles. For N=1 it is constantly 1.
- `div_tick` = 1 exactly in the cycle where cnt = 0. For N=1 it is constantly 1.
- Write (`cfg_wr`=1, `cfg_ch` valid): `shd[cfg_ch]` ← `cfg_div` and `pend` is set.
  - The write is evaluated after any same-edge wrap or sync. A write landing on a wrap edge therefore applies at the following wrap.
  - Rewriting while `pend` is set overwrites `shd`; the last write wins.
- Stopping (act = 0 applied at a wrap):
  - `div_clk` = 0 and `div_tick` = 0; `cnt` holds at 0.
  - A pending nonzero `shd` applies on the next edge and starts a period (tick). Latency is 2 edges from the write.
- `sync`:
  - On the edge it is sampled, every running channel forces `cnt` ← 0 and applies a pending `shd` if `pend` is set.
  - Stopped channels ignore it.
  - If `sync` and `cfg_wr` occur together, sync uses the pre-write `shd` and the write stays pending.
- Reset:
  - `cnt` ← act−1 (with act = DEFAULT_DIV), `shd` ← DEFAULT_DIV, `pend` ← 0.
  - All outputs are 0.
  - Reset asserted mid-period aborts immediately: outputs are 0 on the edge after `rst` is sampled high, and pending writes are discarded.

## Timing
- `div_clk`, `div_tick` and `cfg_pend` are direct flop outputs, with no combinational path from any input.
- First edge with `rst`=0: cnt wraps to 0. `div_clk`=1 and `div_tick`=1 in that cycle (1-cycle latency from reset release).
- Latency from ratio write to the new period: the write edge, plus the remaining cycles of the current period, then the wrap edge.
- `cfg_pend` rises on the write edge and falls on the wrap edge that applies the ratio.
- Sync to tick: 1 edge. All synced channels tick in the same cycle.
- Period wrap arithmetic uses a CNT_W-bit compare of cnt against act−1; no overflow is possible since act ≤ 2^CNT_W−1.

## Test plan
- Reset with DEFAULT_DIV=2, release `rst` → all `div_clk` toggle 1,0,1,0 starting on the first edge; `div_tick` is high every other cycle; `cfg_pend`=0.
- Write ch1 ratio 5 mid-period → `cfg_pend[1]`=1 until the next wrap. After the wrap, `div_clk[1]` follows the pattern 1,1,1,0,0 repeating, and `div_tick[1]` pulses every 5 cycles.
- Write ch0 ratio 0, then ratio 3 ten cycles later → ch0 outputs stay 0 from its wrap onward. It resumes with a tick 2 edges after the second write, and the pattern is 1,1,0.
- Channels at ratios 3, 4, 7 and 1, pulse `sync` → all four `div_tick` are high on the next cycle; the ch3 (N=1) `div_clk` stays constantly 1.
- Write on the exact wrap edge of ch2 (ratio 4 → 6) → the next period is still 4 cycles and the one after is 6 cycles.
- Assert `rst` mid-period with a write pending → outputs go 0 on the next edge. After release, the channel runs at DEFAULT_DIV and `cfg_pend`=0.
- Write with `cfg_ch` = NUM_CH → no state change on any channel.
